// File: rtl/rx_buffer_sched_if.sv
// Stream channel (32-bit data, valid/ready, last) used by the receive scheduler
// for the frame report input, the descriptor writeback output and the
// free-buffer command output.
interface rx_buffer_sched_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/rx_buffer_sched.sv
// Receive buffer scheduler: pairs each captured frame report with a host
// descriptor, issues the local-to-host DMA command, emits the two descriptor
// writeback words and finally returns the local buffer to the capture block.
// One frame is in flight at a time, so local buffers are released in order.
//
// Optional feature macro: RX_SCHED_DROP_EN
//   When defined, a frame that waits DROP_TIMEOUT cycles for a descriptor is
//   dropped (freed without DMA or writeback) and drop_count is incremented.
//   When undefined, the scheduler waits for a descriptor indefinitely and
//   drop_count is tied to zero.
module rx_buffer_sched #(
  parameter int unsigned HOST_ADDR_BITS = 64,
  parameter int unsigned DROP_TIMEOUT   = 4096
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  rx_buffer_sched_if.slave          stat_s,
  input  logic [HOST_ADDR_BITS-1:0] desc_s_tdata,
  input  logic                      desc_s_tvalid,
  output logic                      desc_s_tready,
  output logic [15:0]               dma_cmd_local,
  output logic [HOST_ADDR_BITS-1:0] dma_cmd_host,
  output logic [15:0]               dma_cmd_bytes,
  output logic                      dma_cmd_valid,
  input  logic                      dma_cmd_ready,
  input  logic                      dma_done,
  rx_buffer_sched_if.master         wb_m,
  rx_buffer_sched_if.master         free_m,
  output logic [15:0]               drop_count
);

  localparam int unsigned FIELD_BITS = 16;
  localparam int unsigned WORD_BITS  = 32;
  // Writeback status word: no errors, DD | EOP
  localparam logic [WORD_BITS-1:0] WB_STATUS = 32'h0000_0003;

  // A zero timeout would make the drop path meaningless
  if (DROP_TIMEOUT == 0) begin : g_timeout_range
    $error("rx_buffer_sched: DROP_TIMEOUT must be non-zero");
  end

  typedef enum logic [3:0] {
    S_IDLE,
    S_C1,
    S_C2,
    S_RESYNC,
    S_DESC,
    S_CMD,
    S_DWAIT,
    S_WB0,
    S_WB1,
    S_FREE
  } state_t;

  state_t                state;
  logic [FIELD_BITS-1:0] len;
  logic [FIELD_BITS-1:0] addr;
  logic [FIELD_BITS-1:0] csum;
  logic                  stat_hs;
  logic                  desc_hs;

`ifdef RX_SCHED_DROP_EN
  localparam int unsigned WAIT_BITS = (DROP_TIMEOUT > 1) ? $clog2(DROP_TIMEOUT) : 1;
  localparam logic [WAIT_BITS-1:0] WAIT_LAST = WAIT_BITS'(DROP_TIMEOUT - 1);
  logic [WAIT_BITS-1:0] wait_cnt;
`else
  assign drop_count = 16'h0000;
`endif

  assign stat_hs = stat_s.tvalid && stat_s.tready;
  assign desc_hs = desc_s_tvalid && desc_s_tready;

  // Frame sequencer; every handshake output is registered and only changes on
  // a handshake or a state transition.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= S_IDLE;
      len           <= '0;
      addr          <= '0;
      csum          <= '0;
      stat_s.tready <= 1'b0;
      desc_s_tready <= 1'b0;
      dma_cmd_local <= '0;
      dma_cmd_host  <= '0;
      dma_cmd_bytes <= '0;
      dma_cmd_valid <= 1'b0;
      wb_m.tdata    <= '0;
      wb_m.tvalid   <= 1'b0;
      wb_m.tlast    <= 1'b0;
      free_m.tdata  <= '0;
      free_m.tvalid <= 1'b0;
      free_m.tlast  <= 1'b0;
`ifdef RX_SCHED_DROP_EN
      wait_cnt      <= '0;
      drop_count    <= '0;
`endif
    end else begin
      case (state)
        // First report word: buffer length and local address
        S_IDLE: begin
          stat_s.tready <= 1'b1;
          if (stat_hs) begin
            len   <= stat_s.tdata[31:16];
            addr  <= stat_s.tdata[15:0];
            state <= stat_s.tlast ? S_RESYNC : S_C1;
          end
        end

        // Second report word: checksum (its length copy is redundant)
        S_C1: begin
          if (stat_hs) begin
            csum  <= stat_s.tdata[31:16];
            state <= stat_s.tlast ? S_RESYNC : S_C2;
          end
        end

        // Trailer word must close the report, otherwise the stream is misaligned
        S_C2: begin
          if (stat_hs) begin
            if (stat_s.tlast) begin
              state         <= S_DESC;
              stat_s.tready <= 1'b0;
              desc_s_tready <= 1'b1;
`ifdef RX_SCHED_DROP_EN
              wait_cnt      <= '0;
`endif
            end else begin
              state <= S_RESYNC;
            end
          end
        end

        // Discard up to and including the next word carrying tlast
        S_RESYNC: begin
          if (stat_hs && stat_s.tlast) begin
            state <= S_IDLE;
          end
        end

        // Wait for a host descriptor; empty frames skip the DMA
        S_DESC: begin
          if (desc_hs) begin
            desc_s_tready <= 1'b0;
            dma_cmd_host  <= desc_s_tdata;
            if (len == 16'h0000) begin
              state       <= S_WB0;
              wb_m.tvalid <= 1'b1;
              wb_m.tdata  <= {csum, len};
              wb_m.tlast  <= 1'b0;
            end else begin
              state         <= S_CMD;
              dma_cmd_valid <= 1'b1;
              dma_cmd_local <= addr;
              dma_cmd_bytes <= len;
            end
          end
`ifdef RX_SCHED_DROP_EN
          else if (wait_cnt == WAIT_LAST) begin
            desc_s_tready <= 1'b0;
            state         <= S_FREE;
            free_m.tvalid <= 1'b1;
            free_m.tdata  <= {len, addr};
            free_m.tlast  <= 1'b1;
            if (drop_count != 16'hFFFF) begin
              drop_count <= drop_count + 16'd1;
            end
          end else begin
            wait_cnt <= wait_cnt + WAIT_BITS'(1);
          end
`endif
        end

        // Hold the command until accepted; a done on the same cycle counts
        S_CMD: begin
          if (dma_cmd_ready) begin
            dma_cmd_valid <= 1'b0;
            if (dma_done) begin
              state       <= S_WB0;
              wb_m.tvalid <= 1'b1;
              wb_m.tdata  <= {csum, len};
              wb_m.tlast  <= 1'b0;
            end else begin
              state <= S_DWAIT;
            end
          end
        end

        // Wait for the transfer to land in host memory
        S_DWAIT: begin
          if (dma_done) begin
            state       <= S_WB0;
            wb_m.tvalid <= 1'b1;
            wb_m.tdata  <= {csum, len};
            wb_m.tlast  <= 1'b0;
          end
        end

        // Writeback word 0 {csum,len}
        S_WB0: begin
          if (wb_m.tready) begin
            state      <= S_WB1;
            wb_m.tdata <= WB_STATUS;
            wb_m.tlast <= 1'b1;
          end
        end

        // Writeback word 1 (status), then release the local buffer
        S_WB1: begin
          if (wb_m.tready) begin
            state         <= S_FREE;
            wb_m.tvalid   <= 1'b0;
            wb_m.tlast    <= 1'b0;
            free_m.tvalid <= 1'b1;
            free_m.tdata  <= {len, addr};
            free_m.tlast  <= 1'b1;
          end
        end

        // Free command held until the capture block takes it
        S_FREE: begin
          if (free_m.tready) begin
            state         <= S_IDLE;
            free_m.tvalid <= 1'b0;
            free_m.tlast  <= 1'b0;
            stat_s.tready <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_buffer_sched.sv
// Directed bench for rx_buffer_sched: drives report frames and descriptors,
// models the DMA engine, records every handshake and compares against
// hand-computed expected transactions.
module tb_rx_buffer_sched;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [63:0] desc_tdata;
  logic        desc_tvalid;
  logic        desc_tready;
  logic [15:0] dma_local;
  logic [63:0] dma_host;
  logic [15:0] dma_bytes;
  logic        dma_valid;
  logic        dma_ready;
  logic        dma_done = 1'b0;
  logic [15:0] drop_count;

  logic        done_en;
  logic        rdy_toggle;
  logic        tog = 1'b0;

  int checks = 0;
  int failures = 0;

  rx_buffer_sched_if stat_if ();
  rx_buffer_sched_if wb_if ();
  rx_buffer_sched_if free_if ();

  always #5 aclk = ~aclk;

  rx_buffer_sched #(
    .HOST_ADDR_BITS (64),
    .DROP_TIMEOUT   (16)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .stat_s        (stat_if),
    .desc_s_tdata  (desc_tdata),
    .desc_s_tvalid (desc_tvalid),
    .desc_s_tready (desc_tready),
    .dma_cmd_local (dma_local),
    .dma_cmd_host  (dma_host),
    .dma_cmd_bytes (dma_bytes),
    .dma_cmd_valid (dma_valid),
    .dma_cmd_ready (dma_ready),
    .dma_done      (dma_done),
    .wb_m          (wb_if),
    .free_m        (free_if),
    .drop_count    (drop_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Sink readiness: all ready, or toggling every cycle
  always @(negedge aclk) begin
    if (rdy_toggle) tog = ~tog;
    else            tog = 1'b1;
    wb_if.tready   = tog;
    free_if.tready = ~tog | ~rdy_toggle;
    dma_ready      = tog;
  end

  // DMA engine model: done pulse one cycle after command acceptance
  always begin
    @(posedge aclk);
    if (aresetn && done_en && dma_valid && dma_ready) begin
      @(negedge aclk);
      dma_done = 1'b1;
      @(negedge aclk);
      dma_done = 1'b0;
    end
  end

  // Handshake recorder and hold-while-stalled checks
  logic [95:0] dma_q[$];
  logic [32:0] wb_q[$];
  logic [32:0] free_q[$];
  int          cyc = 0;
  int          c2_cyc = 0;
  int          free_cyc = 0;
  int          dma_seen = 0;
  logic        wb_stall, free_stall, dma_stall, free_v_d;
  logic [32:0] wb_prev, free_prev;
  logic [95:0] dma_prev;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wb_stall   <= 1'b0;
      free_stall <= 1'b0;
      dma_stall  <= 1'b0;
      free_v_d   <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (wb_stall)
        check("wb_hold", 64'({wb_if.tvalid, wb_if.tlast, wb_if.tdata}), 64'({1'b1, wb_prev}));
      if (free_stall)
        check("free_hold", 64'({free_if.tvalid, free_if.tlast, free_if.tdata}), 64'({1'b1, free_prev}));
      if (dma_stall) begin
        check("dma_hold_v", 64'(dma_valid), 64'd1);
        check("dma_hold_h", dma_host, dma_prev[79:16]);
        check("dma_hold_lb", 64'({dma_local, dma_bytes}), 64'({dma_prev[95:80], dma_prev[15:0]}));
      end
      wb_stall   <= wb_if.tvalid && !wb_if.tready;
      free_stall <= free_if.tvalid && !free_if.tready;
      dma_stall  <= dma_valid && !dma_ready;
      wb_prev    <= {wb_if.tlast, wb_if.tdata};
      free_prev  <= {free_if.tlast, free_if.tdata};
      dma_prev   <= {dma_local, dma_host, dma_bytes};
      if (dma_valid) dma_seen <= dma_seen + 1;
      if (stat_if.tvalid && stat_if.tready && stat_if.tlast) c2_cyc <= cyc;
      if (free_if.tvalid && !free_v_d) free_cyc <= cyc;
      free_v_d <= free_if.tvalid;
      if (dma_valid && dma_ready) dma_q.push_back({dma_local, dma_host, dma_bytes});
      if (wb_if.tvalid && wb_if.tready) wb_q.push_back({wb_if.tlast, wb_if.tdata});
      if (free_if.tvalid && free_if.tready) free_q.push_back({free_if.tlast, free_if.tdata});
    end
  end

  task automatic send_word(input logic [31:0] d, input logic last);
    int n = 0;
    stat_if.tdata  = d;
    stat_if.tlast  = last;
    stat_if.tvalid = 1'b1;
    do begin
      @(posedge aclk);
      n++;
    end while (!stat_if.tready && n < 400);
    check("stat_accept", 64'(n < 400), 64'd1);
    @(negedge aclk);
    stat_if.tvalid = 1'b0;
    stat_if.tlast  = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] len, input logic [15:0] addr, input logic [15:0] csum);
    send_word({len, addr}, 1'b0);
    send_word({csum, len}, 1'b0);
    send_word(32'h0, 1'b1);
  endtask

  task automatic give_desc(input logic [63:0] host);
    int n = 0;
    desc_tdata  = host;
    desc_tvalid = 1'b1;
    do begin
      @(posedge aclk);
      n++;
    end while (!desc_tready && n < 400);
    check("desc_accept", 64'(n < 400), 64'd1);
    @(negedge aclk);
    desc_tvalid = 1'b0;
  endtask

  task automatic wait_free(input string tag, input int n);
    int k = 0;
    while (int'(free_q.size()) < n && k < 600) begin
      @(negedge aclk);
      k++;
    end
    repeat (4) @(negedge aclk);
    check({tag, "_nfree"}, 64'(free_q.size()), 64'(n));
  endtask

  task automatic expect_dma(input string tag, input logic [15:0] loc, input logic [63:0] host,
                            input logic [15:0] bytes);
    logic [95:0] e;
    check({tag, "_dma_present"}, 64'(dma_q.size() > 0), 64'd1);
    if (dma_q.size() > 0) begin
      e = dma_q.pop_front();
      check({tag, "_dma_host"}, e[79:16], host);
      check({tag, "_dma_local_bytes"}, 64'({e[95:80], e[15:0]}), 64'({loc, bytes}));
    end
  endtask

  task automatic expect_wb(input string tag, input logic [31:0] w, input logic last);
    logic [32:0] e;
    check({tag, "_wb_present"}, 64'(wb_q.size() > 0), 64'd1);
    if (wb_q.size() > 0) begin
      e = wb_q.pop_front();
      check({tag, "_wb"}, 64'(e), 64'({last, w}));
    end
  endtask

  task automatic expect_free(input string tag, input logic [31:0] w);
    logic [32:0] e;
    check({tag, "_free_present"}, 64'(free_q.size() > 0), 64'd1);
    if (free_q.size() > 0) begin
      e = free_q.pop_front();
      check({tag, "_free"}, 64'(e), 64'({1'b1, w}));
    end
  endtask

  task automatic expect_empty(input string tag);
    check({tag, "_left_over"}, 64'(dma_q.size() + wb_q.size() + free_q.size()), 64'd0);
  endtask

  task automatic clear_q();
    dma_q.delete();
    wb_q.delete();
    free_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    int k;
    aresetn        = 1'b0;
    stat_if.tvalid = 1'b0;
    stat_if.tdata  = '0;
    stat_if.tlast  = 1'b0;
    desc_tvalid    = 1'b0;
    desc_tdata     = '0;
    done_en        = 1'b1;
    rdy_toggle     = 1'b0;
    repeat (3) @(negedge aclk);

    check("rst_valids", 64'({stat_if.tready, desc_tready, dma_valid, wb_if.tvalid, free_if.tvalid,
                              wb_if.tlast, free_if.tlast}), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    check("rst_dma_fields", 64'({dma_local, dma_bytes}), 64'd0);
    check("rst_dma_host", dma_host, 64'd0);
    check("rst_wb_free_data", 64'({wb_if.tdata, free_if.tdata}), 64'd0);
    aresetn = 1'b1;
    @(negedge aclk);

    // Basic frame, all sinks ready
    clear_q();
    fork
      send_frame(16'h0040, 16'h0100, 16'hBEEF);
      give_desc(64'h1000);
    join
    wait_free("t1", 1);
    expect_dma("t1", 16'h0100, 64'h1000, 16'h0040);
    expect_wb("t1_w0", 32'hBEEF_0040, 1'b0);
    expect_wb("t1_w1", 32'h0000_0003, 1'b1);
    expect_free("t1", 32'h0040_0100);
    expect_empty("t1");
    check("t1_latency", 64'(free_cyc - c2_cyc), 64'd6);

    // Three back-to-back frames with stalling sinks
    clear_q();
    rdy_toggle = 1'b1;
    fork
      begin
        send_frame(16'h0010, 16'h0200, 16'h1111);
        send_frame(16'h0020, 16'h0300, 16'h2222);
        send_frame(16'h0030, 16'h0400, 16'h3333);
      end
      begin
        give_desc(64'hDEAD_0000_0000_2000);
        give_desc(64'h0000_0001_0000_3000);
        give_desc(64'h4000);
      end
    join
    wait_free("t2", 3);
    rdy_toggle = 1'b0;
    expect_dma("t2_f1", 16'h0200, 64'hDEAD_0000_0000_2000, 16'h0010);
    expect_dma("t2_f2", 16'h0300, 64'h0000_0001_0000_3000, 16'h0020);
    expect_dma("t2_f3", 16'h0400, 64'h4000, 16'h0030);
    expect_wb("t2_f1_w0", 32'h1111_0010, 1'b0);
    expect_wb("t2_f1_w1", 32'h0000_0003, 1'b1);
    expect_wb("t2_f2_w0", 32'h2222_0020, 1'b0);
    expect_wb("t2_f2_w1", 32'h0000_0003, 1'b1);
    expect_wb("t2_f3_w0", 32'h3333_0030, 1'b0);
    expect_wb("t2_f3_w1", 32'h0000_0003, 1'b1);
    expect_free("t2_f1", 32'h0010_0200);
    expect_free("t2_f2", 32'h0020_0300);
    expect_free("t2_f3", 32'h0030_0400);
    expect_empty("t2");

    // Report with a stray tlast on C1 is discarded through its trailer
    clear_q();
    fork
      begin
        send_word({16'h0050, 16'h0500}, 1'b0);
        send_word({16'hAAAA, 16'h0050}, 1'b1);
        send_word(32'h0, 1'b1);
        send_frame(16'h0060, 16'h0700, 16'h6666);
      end
      give_desc(64'h7000);
    join
    wait_free("t3", 1);
    expect_dma("t3", 16'h0700, 64'h7000, 16'h0060);
    expect_wb("t3_w0", 32'h6666_0060, 1'b0);
    expect_wb("t3_w1", 32'h0000_0003, 1'b1);
    expect_free("t3", 32'h0060_0700);
    expect_empty("t3");

    // Zero-length frame skips the DMA
    clear_q();
    snap = dma_seen;
    fork
      send_frame(16'h0000, 16'h0600, 16'h5A5A);
      give_desc(64'h8000);
    join
    wait_free("t4", 1);
    check("t4_no_dma_valid", 64'(dma_seen - snap), 64'd0);
    expect_wb("t4_w0", 32'h5A5A_0000, 1'b0);
    expect_wb("t4_w1", 32'h0000_0003, 1'b1);
    expect_free("t4", 32'h0000_0600);
    expect_empty("t4");

`ifdef RX_SCHED_DROP_EN
    // Descriptor on the timeout cycle wins
    clear_q();
    send_frame(16'h0080, 16'h0900, 16'h8888);
    repeat (15) @(negedge aclk);
    give_desc(64'h9000);
    wait_free("t5a", 1);
    check("t5a_drop", 64'(drop_count), 64'd0);
    expect_dma("t5a", 16'h0900, 64'h9000, 16'h0080);
    expect_wb("t5a_w0", 32'h8888_0080, 1'b0);
    expect_wb("t5a_w1", 32'h0000_0003, 1'b1);
    expect_free("t5a", 32'h0080_0900);
    expect_empty("t5a");

    // No descriptor: dropped after 16 cycles
    clear_q();
    send_frame(16'h0070, 16'h0800, 16'h7777);
    k = 0;
    while (!free_if.tvalid && k < 100) begin
      @(negedge aclk);
      k++;
    end
    check("t5b_timeout_cycles", 64'(k), 64'd16);
    wait_free("t5b", 1);
    check("t5b_drop", 64'(drop_count), 64'd1);
    expect_free("t5b", 32'h0070_0800);
    expect_empty("t5b");
`else
    // Without the drop feature the scheduler waits for a descriptor
    clear_q();
    send_frame(16'h0070, 16'h0800, 16'h7777);
    repeat (40) @(negedge aclk);
    check("t5_waiting", 64'({free_if.tvalid, desc_tready}), 64'b01);
    check("t5_drop", 64'(drop_count), 64'd0);
    give_desc(64'h8800);
    wait_free("t5", 1);
    expect_dma("t5", 16'h0800, 64'h8800, 16'h0070);
    expect_wb("t5_w0", 32'h7777_0070, 1'b0);
    expect_wb("t5_w1", 32'h0000_0003, 1'b1);
    expect_free("t5", 32'h0070_0800);
    expect_empty("t5");
`endif

    // Reset while waiting for DMA completion abandons the frame
    clear_q();
    done_en = 1'b0;
    fork
      send_frame(16'h0090, 16'h0A00, 16'h9999);
      give_desc(64'hA000);
    join
    k = 0;
    while (dma_q.size() == 0 && k < 200) begin
      @(negedge aclk);
      k++;
    end
    check("t6_dma_issued", 64'(dma_q.size()), 64'd1);
    repeat (2) @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check("t6_rst_valids", 64'({stat_if.tready, desc_tready, dma_valid, wb_if.tvalid, free_if.tvalid}),
          64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    done_en = 1'b1;
    clear_q();
    fork
      send_frame(16'h00A0, 16'h0B00, 16'hAAAA);
      give_desc(64'hB000);
    join
    wait_free("t6", 1);
    expect_dma("t6", 16'h0B00, 64'hB000, 16'h00A0);
    expect_wb("t6_w0", 32'hAAAA_00A0, 1'b0);
    expect_wb("t6_w1", 32'h0000_0003, 1'b1);
    expect_free("t6", 32'h00A0_0B00);
    expect_empty("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_buffer_sched.md
Name: rx_buffer_sched

Overview:
- Sequences the receive path between the frame-capture block and host delivery.
- Consumes the 3-word per-frame report stream (buffer length/address, checksum, trailer) and pairs each frame with a host descriptor buffer.
- Issues a local-RAM-to-host DMA command, then emits the descriptor writeback words.
- Returns the consumed local buffer length to the capture block's free-buffer command port, so local RAM is released strictly in frame order.

Parameters:
- HOST_ADDR_BITS, 64, width of host buffer address from descriptor.
- DROP_TIMEOUT, 4096, cycles waiting for a descriptor before a frame is dropped (used only with RX_SCHED_DROP_EN).

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- stat_s_tdata  in  32  report word: C0 {len[31:16],addr[15:0]}, C1 {csum[31:16],len[15:0]}, C2 zero
- stat_s_tvalid  in  1  report valid
- stat_s_tlast  in  1  asserted on C2
- stat_s_tready  out  1  report accept
- desc_s_tdata  in  HOST_ADDR_BITS  host buffer address of next free descriptor
- desc_s_tvalid  in  1  descriptor available
- desc_s_tready  out  1  descriptor consumed
- dma_cmd_local  out  16  local RAM byte address
- dma_cmd_host  out  HOST_ADDR_BITS  host byte address
- dma_cmd_bytes  out  16  transfer length
- dma_cmd_valid  out  1  command valid
- dma_cmd_ready  in  1  command accepted
- dma_done  in  1  one-cycle pulse, transfer complete
- wb_m_tdata  out  32  writeback: W0 {csum,len}, W1 {16'h0,8'h00 errors,8'h03 status DD|EOP}
- wb_m_tvalid  out  1
- wb_m_tlast  out  1  on W1
- wb_m_tready  in  1
- free_m_tdata  out  32  {len[31:16],addr[15:0]} freed buffer
- free_m_tvalid  out  1
- free_m_tlast  out  1  always 1 when valid
- free_m_tready  in  1
- drop_count  out  16  frames dropped, saturating

Behaviour:
- Reset values: all valid outputs 0, stat_s_tready 0, desc_s_tready 0, drop_count 0; data outputs 0.
- Registered FSM, one frame in flight. Reset mid-operation abandons the frame; nothing is freed.
- S_IDLE: stat_s_tready=1.
  - Accepted C0 latches len and addr -> S_C1.
  - If tlast is seen on C0 -> S_RESYNC.
- S_C1: accept, latch csum.
  - tlast here -> S_RESYNC.
  - Otherwise -> S_C2.
- S_C2: accept one word.
  - tlast=1 -> S_DESC.
  - tlast=0 -> S_RESYNC.
- S_RESYNC: discard words until an accepted word with tlast -> S_IDLE. The frame is not freed.
- stat_s_tready is 0 in all other states.
- S_DESC: desc_s_tready=1.
  - On handshake, latch host address.
  - len==0 -> S_WB0, no DMA.
  - Otherwise -> S_CMD.
- S_CMD: dma_cmd_valid=1, fields stable until dma_cmd_ready; then -> S_DWAIT.
- S_DWAIT: wait for dma_done.
  - A done pulse coincident with the cmd handshake counts.
  - done pulses in any other state are ignored.
- S_WB0: wb_m_tvalid=1, W0.
- S_WB1: W1 with tlast.
- Each writeback word advances only on wb_m_tready.
- S_FREE: free_m_tvalid=1, {len,addr} held until free_m_tready -> S_IDLE.
- Free occurs only after writeback completes.
- Minimum latency from C2 accept to free_m_tvalid, when desc/dma/wb are always ready and done arrives 1 cycle after cmd: 6 cycles.
- All valid/data outputs are registered. Valid never drops without a handshake.

Optional Feature:
- Macro RX_SCHED_DROP_EN.
- With the macro:
  - A wait counter clears on entry to S_DESC.
  - If it reaches DROP_TIMEOUT with no descriptor, -> S_FREE directly: no DMA, no writeback, and drop_count increments, saturating at 16'hFFFF.
  - A descriptor arriving on the timeout cycle wins.
- Without the macro: S_DESC waits indefinitely and drop_count is constant 0.

Test Plan:
- Report {0x0040,0x0100},{csum 0xBEEF,0x0040},0; desc 0x1000 -> dma (local 0x0100, host 0x1000, bytes 0x40); wb 0xBEEF0040 then 0x00000003 with tlast; free 0x00400100.
- Three back-to-back frames with wb_m_tready and free_m_tready toggling every cycle -> frees in order, each exactly once, data stable while stalled.
- Report with tlast on C1, then a valid frame -> malformed frame produces no DMA, wb or free; the next frame completes normally.
- len=0 frame -> no dma_cmd_valid; wb W0 = {csum,0x0000}; free 0x0000xxxx.
- RX_SCHED_DROP_EN, DROP_TIMEOUT=16, no descriptor -> free after 16 cycles, drop_count=1, no wb; a descriptor on cycle 16 -> normal DMA, drop_count stays 0.
- Assert aresetn low during S_DWAIT -> all valids 0 next edge; after release the next frame is processed from S_IDLE.
